sram_controller: RTL and testbench

- Word-wide external asynchronous SRAM controller (256K x 16 class device).
- Sits directly downstream of ext_memInterface on its SRAM port: it consumes addr/re/we/data_io_sram and returns needWait_i_sram.
- Converts the single-cycle-request / needWait handshake into timed CE#/OE#/WE# strobe sequences on the external pins.

---
 rtl/sram_pkg.sv | 32 +++
 rtl/sram_controller_if.sv | 35 +++
 rtl/sram_controller.sv | 195 +++++++++++++++++++
 tb/tb_sram_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the external asynchronous memory port controllers:
// the controller state encoding, default pin timing and a helper that sizes
// the wait-state counter.
// No ports (package).
// -----------------------------------------------------------------------------
package sram_pkg;

    localparam int DEF_ADDR_WIDTH = 18;
    localparam int DEF_READ_WAIT  = 2;
    localparam int DEF_WRITE_WAIT = 2;
    localparam int DATA_WIDTH     = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        ACK      = 3'd5
    } sram_state_t;

    // Counter must hold the larger wait value; one extra bit keeps a load of
    // an exact power of two representable.
    function automatic int wait_cnt_width(input int rd_wait, input int wr_wait);
        int max_wait;
        max_wait = (rd_wait > wr_wait) ? rd_wait : wr_wait;
        return $clog2(max_wait) + 1;
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// -----------------------------------------------------------------------------
// sram_controller_if
// Request/handshake bundle between ext_memInterface (master) and the SRAM
// controller (slave). The shared 16-bit data bus stays a plain inout net on
// the controller because it is bidirectional.
//   addr_i     : word address, master -> controller
//   re_i       : read request, held until acknowledged
//   we_i       : write request, held until acknowledged
//   needWait_o : controller -> master, high while a held request is pending
// -----------------------------------------------------------------------------
interface sram_controller_if #(
    parameter int ADDR_WIDTH = sram_pkg::DEF_ADDR_WIDTH
) ();
    import sram_pkg::*;

    logic [ADDR_WIDTH-1:0] addr_i;
    logic                  re_i;
    logic                  we_i;
    logic                  needWait_o;

    modport master (
        output addr_i,
        output re_i,
        output we_i,
        input  needWait_o
    );

    modport slave (
        input  addr_i,
        input  re_i,
        input  we_i,
        output needWait_o
    );

endinterface

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
// Turns single-cycle requests with a needWait handshake into timed CE#/OE#/WE#
// strobe sequences for a 256K x 16 asynchronous SRAM.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : addr_i / re_i / we_i / needWait_o handshake
//   data_io       : shared data bus; write data sampled at accept, read data
//                   driven only in the acknowledge cycle of a live read
//   sram_addr_o   : registered SRAM address
//   sram_dq_io    : SRAM data pins, driven only during the write phases
//   sram_ce_n_o, sram_oe_n_o, sram_we_n_o : registered active-low strobes
//   sram_ub_n_o, sram_lb_n_o : byte enables, tied active
// -----------------------------------------------------------------------------
module sram_controller
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int READ_WAIT  = DEF_READ_WAIT,
    parameter int WRITE_WAIT = DEF_WRITE_WAIT
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_controller_if.slave      bus,
    inout  wire  [DATA_WIDTH-1:0] data_io,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    inout  wire  [DATA_WIDTH-1:0] sram_dq_io,
    output logic                  sram_ce_n_o,
    output logic                  sram_oe_n_o,
    output logic                  sram_we_n_o,
    output logic                  sram_ub_n_o,
    output logic                  sram_lb_n_o
);

    localparam int CNT_W = wait_cnt_width(READ_WAIT, WRITE_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_RD_LOAD = CNT_W'(READ_WAIT);
    localparam logic [CNT_W-1:0] CNT_WR_LOAD = CNT_W'(WRITE_WAIT);

    sram_state_t           r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [DATA_WIDTH-1:0] r_wdata_q;
    logic [DATA_WIDTH-1:0] r_rdata_q;
    logic                  r_ack_q;
    logic                  r_is_read;
    logic                  r_ce_n;
    logic                  r_oe_n;
    logic                  r_we_n;
    logic                  r_dq_oe;

    sram_state_t           w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_latch_wr;
    logic                  w_latch_rd;
    logic                  w_capture;
    logic                  w_ce_n_nxt;
    logic                  w_oe_n_nxt;
    logic                  w_we_n_nxt;
    logic                  w_dq_oe_nxt;
    logic                  w_ack_nxt;

    // Next-state, counter and latch-enable decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch_wr  = 1'b0;
        w_latch_rd  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                // Write wins when both requests are raised together.
                if (bus.we_i) begin
                    w_state_nxt = WR_SETUP;
                    w_cnt_nxt   = CNT_WR_LOAD;
                    w_latch_wr  = 1'b1;
                end else if (bus.re_i) begin
                    w_state_nxt = RD;
                    w_cnt_nxt   = CNT_RD_LOAD;
                    w_latch_rd  = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RD: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = ACK;
                    w_capture   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
            WR_SETUP: begin
                w_state_nxt = WR_PULSE;
            end
            WR_PULSE: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = WR_HOLD;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
            WR_HOLD: begin
                w_state_nxt = ACK;
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Pin values for the state being entered, so the registered strobes line
    // up with the state register instead of trailing it by a cycle.
    always_comb begin
        w_ce_n_nxt  = 1'b1;
        w_oe_n_nxt  = 1'b1;
        w_we_n_nxt  = 1'b1;
        w_dq_oe_nxt = 1'b0;
        w_ack_nxt   = 1'b0;
        case (w_state_nxt)
            RD: begin
                w_ce_n_nxt = 1'b0;
                w_oe_n_nxt = 1'b0;
            end
            WR_SETUP, WR_HOLD: begin
                w_ce_n_nxt  = 1'b0;
                w_dq_oe_nxt = 1'b1;
            end
            WR_PULSE: begin
                w_ce_n_nxt  = 1'b0;
                w_we_n_nxt  = 1'b0;
                w_dq_oe_nxt = 1'b1;
            end
            ACK: begin
                w_ack_nxt = 1'b1;
            end
            default: begin
                w_ack_nxt = 1'b0;
            end
        endcase
    end

    // State, strobe and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_rdata_q <= '0;
            r_ack_q   <= 1'b0;
            r_is_read <= 1'b0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_dq_oe   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack_q <= w_ack_nxt;
            r_ce_n  <= w_ce_n_nxt;
            r_oe_n  <= w_oe_n_nxt;
            r_we_n  <= w_we_n_nxt;
            r_dq_oe <= w_dq_oe_nxt;
            if (w_latch_wr) begin
                r_addr_q  <= bus.addr_i;
                r_wdata_q <= data_io;
                r_is_read <= 1'b0;
            end else if (w_latch_rd) begin
                r_addr_q  <= bus.addr_i;
                r_is_read <= 1'b1;
            end
            if (w_capture) begin
                r_rdata_q <= sram_dq_io;
            end
        end
    end

    assign bus.needWait_o = (bus.re_i | bus.we_i) & ~r_ack_q;

    // Read data goes back only if the master is still asking for it.
    assign data_io    = (r_state == ACK && r_is_read && bus.re_i) ? r_rdata_q : {DATA_WIDTH{1'bz}};
    assign sram_dq_io = r_dq_oe ? r_wdata_q : {DATA_WIDTH{1'bz}};

    assign sram_addr_o = r_addr_q;
    assign sram_ce_n_o = r_ce_n;
    assign sram_oe_n_o = r_oe_n;
    assign sram_we_n_o = r_we_n;
    assign sram_ub_n_o = 1'b0;
    assign sram_lb_n_o = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
// Bench for sram_controller: behavioural async SRAM on the pins, a vector
// table of directed accesses, hand-written multi-cycle corner sequences and
// a randomized read/write mix checked against a transaction-level memory map.
// Pull-ups on both data buses make a released bus read back as 16'hFFFF.
// -----------------------------------------------------------------------------
module tb_sram_controller;

    localparam int AW     = 18;
    localparam int RW     = 2;
    localparam int WW     = 2;
    localparam int LAT_RD = RW + 1;
    localparam int LAT_WR = WW + 3;
    localparam logic [15:0] REL = 16'hFFFF;

    logic clk = 1'b0;
    logic rst;
    logic        tb_drv_en;
    logic [15:0] tb_drv_data;

    wire  [15:0]   data_io;
    wire  [15:0]   sram_dq;
    logic [AW-1:0] sram_addr;
    logic sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    sram_controller_if #(.ADDR_WIDTH(AW)) bus ();

    sram_controller #(.ADDR_WIDTH(AW), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .data_io     (data_io),
        .sram_addr_o (sram_addr),
        .sram_dq_io  (sram_dq),
        .sram_ce_n_o (sram_ce_n),
        .sram_oe_n_o (sram_oe_n),
        .sram_we_n_o (sram_we_n),
        .sram_ub_n_o (sram_ub_n),
        .sram_lb_n_o (sram_lb_n)
    );

    always #5 clk = ~clk;

    pullup (data_io);
    pullup (sram_dq);
    assign data_io = tb_drv_en ? tb_drv_data : 16'hzzzz;

    // Behavioural async SRAM: drives on CE#&OE#, commits on WE# rising.
    logic [15:0] sram_mem [0:262143];
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 16'hzzzz;
    always @(posedge sram_we_n) begin
        if (!sram_ce_n) sram_mem[sram_addr] <= sram_dq;
    end

    // Pin monitor: strobe-low counters and bus rule violations.
    logic        mon_en = 1'b0;
    logic [15:0] mon_wdata = 16'h0000;
    int mon_we_low = 0;
    int mon_oe_low = 0;
    int mon_viol   = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (!sram_we_n) mon_we_low <= mon_we_low + 1;
            if (!sram_oe_n) mon_oe_low <= mon_oe_low + 1;
            if ((!sram_oe_n && (!sram_we_n || sram_dq !== sram_mem[sram_addr])) ||
                (sram_ce_n && sram_dq !== REL) ||
                (!sram_ce_n && sram_oe_n && sram_dq !== mon_wdata) ||
                (sram_ub_n !== 1'b0) || (sram_lb_n !== 1'b0)) begin
                mon_viol <= mon_viol + 1;
                $display("bus rule broken at %0t: ce_n=%b oe_n=%b we_n=%b dq=%h", $time,
                         sram_ce_n, sram_oe_n, sram_we_n, sram_dq);
            end
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference model: word-addressed memory, unwritten words read as zero.
    logic [15:0] ref_mem [logic [AW-1:0]];

    function automatic logic [15:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete access, starting at posedge+1 of an IDLE cycle and ending
    // at posedge+1 of the IDLE cycle after the acknowledge.
    task automatic access(input string tag, input logic re, input logic we,
                          input logic [AW-1:0] a, input logic [15:0] d,
                          input logic chk_rd, input logic [15:0] exp_rd);
        int cyc, we0, oe0, v0;
        logic done;
        logic [15:0] got;
        we0 = mon_we_low; oe0 = mon_oe_low; v0 = mon_viol;
        mon_wdata   = d;
        bus.addr_i  = a;
        bus.re_i    = re;
        bus.we_i    = we;
        tb_drv_data = d;
        tb_drv_en   = we;
        cyc = 0; done = 1'b0; got = 16'h0000;
        while (!done && cyc < 40) begin
            #1;
            if (!bus.needWait_o) begin
                done = 1'b1;
                got  = data_io;
            end else begin
                @(posedge clk); #1;
                cyc++;
                if (cyc == 1) begin
                    // Post-accept changes must not reach the SRAM.
                    bus.addr_i  = ~a;
                    tb_drv_data = ~d;
                end
            end
        end
        bus.re_i = 1'b0; bus.we_i = 1'b0; tb_drv_en = 1'b0;
        @(posedge clk); #1;
        check({tag, " latency"}, cyc, we ? LAT_WR : LAT_RD);
        if (chk_rd) check({tag, " rdata"}, got, exp_rd);
        check({tag, " we_low"}, mon_we_low - we0, we ? WW : 0);
        check({tag, " oe_low"}, mon_oe_low - oe0, we ? 0 : RW);
        check({tag, " bus_rules"}, mon_viol - v0, 0);
        if (we) begin
            check({tag, " sram_holds"}, sram_mem[a], d);
            ref_mem[a] = d;
        end
    endtask

    typedef struct {
        logic          re;
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic          chk;
        logic [15:0]   exp;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, v0, oe0, wait_cyc;
        logic rd_re, rd_we;
        logic [1:0] op;
        logic [AW-1:0] ra;
        logic [15:0] rd;

        vecs[0]  = '{1'b0, 1'b1, 18'h00123, 16'hBEEF, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 18'h00123, 16'h0000, 1'b1, 16'hBEEF};
        vecs[2]  = '{1'b1, 1'b1, 18'h3FFFF, 16'h1234, 1'b0, 16'h0000};
        vecs[3]  = '{1'b1, 1'b0, 18'h3FFFF, 16'h0000, 1'b1, 16'h1234};
        vecs[4]  = '{1'b0, 1'b1, 18'h00000, 16'h0F0F, 1'b0, 16'h0000};
        vecs[5]  = '{1'b1, 1'b0, 18'h00000, 16'h0000, 1'b1, 16'h0F0F};
        vecs[6]  = '{1'b1, 1'b0, 18'h00007, 16'h0000, 1'b1, 16'h0000};
        vecs[7]  = '{1'b0, 1'b1, 18'h00001, 16'hA1A1, 1'b0, 16'h0000};
        vecs[8]  = '{1'b0, 1'b1, 18'h00002, 16'hB2B2, 1'b0, 16'h0000};
        vecs[9]  = '{1'b1, 1'b0, 18'h00001, 16'h0000, 1'b1, 16'hA1A1};
        vecs[10] = '{1'b1, 1'b0, 18'h00002, 16'h0000, 1'b1, 16'hB2B2};
        vecs[11] = '{1'b0, 1'b1, 18'h00123, 16'h5A5A, 1'b0, 16'h0000};
        vecs[12] = '{1'b1, 1'b0, 18'h00123, 16'h0000, 1'b1, 16'h5A5A};

        for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0000;

        // Reset state.
        rst = 1'b1; bus.re_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0;
        tb_drv_en = 1'b0; tb_drv_data = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("reset ce_n", sram_ce_n, 1'b1);
        check("reset oe_n", sram_oe_n, 1'b1);
        check("reset we_n", sram_we_n, 1'b1);
        check("reset addr", sram_addr, 18'h00000);
        check("reset dq released", sram_dq, REL);
        check("reset data_io released", data_io, REL);
        check("reset needwait idle", bus.needWait_o, 1'b0);
        bus.we_i = 1'b1; #1;
        check("reset needwait follows request", bus.needWait_o, 1'b1);
        bus.we_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            access($sformatf("vec%0d", i), vecs[i].re, vecs[i].we, vecs[i].addr,
                   vecs[i].data, vecs[i].chk, vecs[i].exp);
        end

        // Request dropped one cycle into a read.
        oe0 = mon_oe_low; v0 = mon_viol;
        bus.addr_i = 18'h00123; bus.re_i = 1'b1;
        @(posedge clk); #1;
        bus.re_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1;
        check("drop ack needwait", bus.needWait_o, 1'b0);
        check("drop data_io released", data_io, REL);
        @(posedge clk); #1;
        check("drop read ran to end", mon_oe_low - oe0, RW);
        check("drop bus_rules", mon_viol - v0, 0);
        access("drop_follow", 1'b1, 1'b0, 18'h00123, 16'h0000, 1'b1, 16'h5A5A);

        // Reset during the WE# pulse.
        mon_wdata = 16'h7777; bus.addr_i = 18'h00100; bus.we_i = 1'b1;
        tb_drv_data = 16'h7777; tb_drv_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1;
        check("rstmid in pulse we_n", sram_we_n, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid we_n", sram_we_n, 1'b1);
        check("rstmid ce_n", sram_ce_n, 1'b1);
        check("rstmid oe_n", sram_oe_n, 1'b1);
        check("rstmid dq released", sram_dq, REL);
        check("rstmid needwait", bus.needWait_o, 1'b1);
        bus.we_i = 1'b0; tb_drv_en = 1'b0;
        #1;
        check("rstmid needwait dropped", bus.needWait_o, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        access("rstmid_follow", 1'b1, 1'b0, 18'h00002, 16'h0000, 1'b1, 16'hB2B2);

        // Back-to-back reads with re_i held and address switched at ack.
        bus.addr_i = 18'h00001; bus.re_i = 1'b1;
        t0 = -1; wait_cyc = 0;
        for (int k = 0; k < 2; k++) begin
            logic done;
            done = 1'b0;
            while (!done && wait_cyc < 40) begin
                #1;
                if (!bus.needWait_o) begin
                    done = 1'b1;
                    check($sformatf("b2b ack%0d data", k), data_io, (k == 0) ? 16'hA1A1 : 16'hB2B2);
                    check($sformatf("b2b ack%0d cycle", k), wait_cyc, (k == 0) ? LAT_RD : LAT_RD + LAT_RD + 1);
                    if (k == 0) t0 = wait_cyc;
                    else check("b2b spacing", wait_cyc - t0, 4);
                    bus.addr_i = 18'h00002;
                end
                @(posedge clk); #1;
                wait_cyc++;
            end
            if (!done) check($sformatf("b2b ack%0d seen", k), 32'd0, 32'd1);
        end
        bus.re_i = 1'b0;
        @(posedge clk); #1;

        // Randomized mix against the reference memory.
        for (int n = 0; n < 1000; n++) begin
            op = 2'($urandom_range(0, 3));
            rd_re = (op != 2'd2);
            rd_we = (op >= 2'd2);
            ra = ($urandom_range(0, 7) == 0) ? 18'h3FFFF : 18'($urandom_range(0, 15));
            rd = 16'($urandom_range(0, 65535));
            access($sformatf("rnd%0d", n), rd_re, rd_we, ra, rd, !rd_we, ref_read(ra));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
